// File: rtl/uart_image_streamer_if.sv
// -----------------------------------------------------------------------------
// uart_image_streamer_if
// Groups the streamer's control handshake, image-memory read port and UART
// serial output into one bundle.
//   start    : request to stream one image (host -> streamer)
//   busy     : image in progress (streamer -> host)
//   done     : one-cycle completion pulse (streamer -> host)
//   mem_addr : read address to the image memory (streamer -> memory)
//   mem_data : read data, valid the cycle after mem_addr (memory -> streamer)
//   tx       : UART 8N1 serial line, idle high (streamer -> receiver)
// Modports:
//   master : the streamer itself (drives the memory bus and the serial line)
//   slave  : the environment (host, memory and receiver)
// -----------------------------------------------------------------------------
interface uart_image_streamer_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              tx;

  modport master (
    input  start,
    input  mem_data,
    output mem_addr,
    output tx,
    output busy,
    output done
  );

  modport slave (
    output start,
    output mem_data,
    input  mem_addr,
    input  tx,
    input  busy,
    input  done
  );
endinterface

// File: rtl/uart_image_streamer.sv
// -----------------------------------------------------------------------------
// uart_image_streamer
// Reads NUM_BYTES bytes from a synchronous-read image memory (addresses
// 0..NUM_BYTES-1) and sends each one as an 8N1 UART frame on tx, LSB first.
// done pulses for one cycle after the final stop bit of the image.
//
// Ports:
//   clk : system clock
//   rst : synchronous reset, active high (wins over start)
//   bus : uart_image_streamer_if.master
//         start (in), mem_data (in), mem_addr (out), tx (out),
//         busy (out), done (out)
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | line idle high, address parked at 0, waiting for start
// FETCH  | current address presented to memory (1 cycle)
// LOAD   | memory data captured into the shift register (1 cycle)
// START  | start bit (tx=0) for CLKS_PER_BIT cycles
// DATA   | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// STOP   | stop bit (tx=1) for CLKS_PER_BIT cycles, then next byte or done
// -----------------------------------------------------------------------------
module uart_image_streamer #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int NUM_BYTES    = 784,
  parameter int ADDR_W       = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_image_streamer_if.master bus
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q,  baud_d;
  logic [2:0]        bit_q,   bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              tx_q,    tx_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  logic baud_last;
  assign baud_last = (baud_q == BAUD_LAST);

  // tx_d is always the value tx must show in the state being entered, so the
  // registered line only moves on state/bit boundaries.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        addr_d = '0;
        busy_d = 1'b0;
        if (bus.start) begin
          state_d = S_FETCH;
          busy_d  = 1'b1;
        end
      end

      S_FETCH: begin
        state_d = S_LOAD;
      end

      S_LOAD: begin
        shift_d = bus.mem_data;
        baud_d  = '0;
        tx_d    = 1'b0;
        state_d = S_START;
      end

      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            // shift_q[1] becomes shift[0] on this same edge
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (addr_q == ADDR_LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            addr_d  = '0;
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        addr_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.mem_addr = addr_q;
  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_uart_image_streamer.sv
// -----------------------------------------------------------------------------
// tb_uart_image_streamer
// Three streamer instances (CLKS_PER_BIT=4) sharing clk/rst:
//   u_dut1 : NUM_BYTES=1, mem = {A5}
//   u_dut3 : NUM_BYTES=3, mem = {00, FF, 3C}
//   u_dut2 : NUM_BYTES=2, mem = {5A, C3}
// Cycle index k counts edges after the start-accepting edge (k=0 is the
// cycle right after that edge); outputs are sampled 1 ns after each edge.
// A value visible at index k is captured by edge k+1, so the done pulse seen
// at k = NUM_BYTES*(10*C+2) corresponds to NUM_BYTES*(10*C+2)+1 cycles.
// -----------------------------------------------------------------------------
module tb_uart_image_streamer;

  localparam int C     = 4;
  localparam int FRAME = 10 * C + 2;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  uart_image_streamer_if #(.ADDR_W(4)) ifc1 ();
  uart_image_streamer_if #(.ADDR_W(4)) ifc3 ();
  uart_image_streamer_if #(.ADDR_W(4)) ifc2 ();

  uart_image_streamer #(.CLKS_PER_BIT(C), .NUM_BYTES(1), .ADDR_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .bus(ifc1)
  );
  uart_image_streamer #(.CLKS_PER_BIT(C), .NUM_BYTES(3), .ADDR_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .bus(ifc3)
  );
  uart_image_streamer #(.CLKS_PER_BIT(C), .NUM_BYTES(2), .ADDR_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .bus(ifc2)
  );

  logic [7:0] mem1 [0:15];
  logic [7:0] mem3 [0:15];
  logic [7:0] mem2 [0:15];

  always @(posedge clk) begin
    ifc1.mem_data <= mem1[ifc1.mem_addr];
    ifc3.mem_data <= mem3[ifc3.mem_addr];
    ifc2.mem_data <= mem2[ifc2.mem_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected tx at index j of an image of n bytes: 2 idle-high cycles
  // (FETCH, LOAD) then a 10-bit frame of C cycles per bit, per byte.
  function automatic logic exp_tx(input int j, input int n,
                                  input logic [7:0] b0, input logic [7:0] b1,
                                  input logic [7:0] b2);
    int i, o, bi;
    logic [7:0] b;
    if (j < 0) return 1'b1;
    i = j / FRAME;
    o = j % FRAME;
    if (i >= n) return 1'b1;
    b = (i == 0) ? b0 : ((i == 1) ? b1 : b2);
    if (o < 2) return 1'b1;
    bi = (o - 2) / C;
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    return b[bi-1];
  endfunction

  // Observations from one streaming run of u_dut3
  int rx_n, start_n, addr_n, done_n, done_k, tx_bad, busy_bad, overlap, frame_err, addr_max;
  logic [7:0] rx_byte [0:7];
  int         start_k [0:7];
  logic [3:0] addr_log [0:7];

  // Streams one image on u_dut3, optionally pulsing start again at poke_k,
  // and decodes tx with a mid-bit-sampling UART receiver.
  task automatic stream3(input int poke_k);
    logic       rx_act;
    int         rx_cnt;
    logic [7:0] rx_sh;
    logic       t;
    rx_n = 0; start_n = 0; addr_n = 0; done_n = 0; done_k = -1;
    tx_bad = 0; busy_bad = 0; overlap = 0; frame_err = 0; addr_max = 0;
    rx_act = 1'b0; rx_cnt = 0; rx_sh = '0;
    ifc3.start = 1'b1;
    tick;
    ifc3.start = 1'b0;
    for (int k = 0; k <= 135; k++) begin
      if (k > 0) tick;
      t = ifc3.tx;
      if (t !== exp_tx(k, 3, 8'h00, 8'hFF, 8'h3C)) tx_bad++;
      if (ifc3.busy !== (k < 3 * FRAME)) busy_bad++;
      if (ifc3.done === 1'b1) begin
        done_n++;
        done_k = k;
      end
      if (ifc3.done === 1'b1 && ifc3.busy === 1'b1) overlap++;
      if (ifc3.busy === 1'b1) begin
        if (int'(ifc3.mem_addr) > addr_max) addr_max = int'(ifc3.mem_addr);
        if ((addr_n == 0 || addr_log[addr_n-1] !== ifc3.mem_addr) && addr_n < 8) begin
          addr_log[addr_n] = ifc3.mem_addr;
          addr_n++;
        end
      end
      if (!rx_act) begin
        if (t === 1'b0) begin
          rx_act = 1'b1;
          rx_cnt = 0;
          if (start_n < 8) start_k[start_n] = k;
          start_n++;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt % C == C / 2) begin
          if (rx_cnt / C >= 1 && rx_cnt / C <= 8) begin
            rx_sh = {t, rx_sh[7:1]};
          end else if (rx_cnt / C == 9) begin
            if (t !== 1'b1) frame_err++;
            if (rx_n < 8) rx_byte[rx_n] = rx_sh;
            rx_n++;
            rx_act = 1'b0;
          end
        end
      end
      if (k == poke_k) ifc3.start = 1'b1;
      if (k == poke_k + 1) ifc3.start = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ifc1.start = 1'b1; ifc3.start = 1'b1; ifc2.start = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick;
      checks++;
      if (ifc1.tx !== 1'b1 || ifc1.busy !== 1'b0 || ifc1.done !== 1'b0 || ifc1.mem_addr !== 4'd0) begin
        errors++;
        $display("FAIL reset_dut1 cycle %0d: tx=%b busy=%b done=%b addr=%0d, want 1 0 0 0",
                 c, ifc1.tx, ifc1.busy, ifc1.done, ifc1.mem_addr);
      end
      checks++;
      if (ifc3.tx !== 1'b1 || ifc3.busy !== 1'b0 || ifc3.done !== 1'b0 || ifc3.mem_addr !== 4'd0) begin
        errors++;
        $display("FAIL reset_dut3 cycle %0d: tx=%b busy=%b done=%b addr=%0d, want 1 0 0 0",
                 c, ifc3.tx, ifc3.busy, ifc3.done, ifc3.mem_addr);
      end
    end
    rst = 1'b0;
    ifc1.start = 1'b0; ifc3.start = 1'b0; ifc2.start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick;
      checks++;
      if (ifc2.tx !== 1'b1 || ifc2.busy !== 1'b0 || ifc1.tx !== 1'b1 || ifc1.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_frame cycle %0d: tx1=%b busy1=%b tx2=%b busy2=%b, want idle",
                 c, ifc1.tx, ifc1.busy, ifc2.tx, ifc2.busy);
      end
    end
  endtask

  task automatic test_single_byte;
    logic [9:0] frame_got;
    logic [9:0] frame_exp;
    int bad, dn, dk, bbad, ov;
    frame_exp = 10'b1101001010;  // A5 framed: 0,1,0,1,0,0,1,0,1,1 (bit0 first)
    frame_got = '0;
    bad = 0; dn = 0; dk = -1; bbad = 0; ov = 0;
    ifc1.start = 1'b1;
    tick;
    ifc1.start = 1'b0;
    checks++;
    if (ifc1.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_after_accept: busy=%b want 1", ifc1.busy);
    end
    for (int k = 0; k <= 48; k++) begin
      if (k > 0) tick;
      if (ifc1.tx !== exp_tx(k, 1, 8'hA5, 8'h00, 8'h00)) bad++;
      if (ifc1.busy !== (k < FRAME)) bbad++;
      if (ifc1.done === 1'b1) begin dn++; dk = k; end
      if (ifc1.done === 1'b1 && ifc1.busy === 1'b1) ov++;
      for (int i = 0; i < 10; i++)
        if (k == 2 + i * C + C / 2) frame_got[i] = ifc1.tx;
    end
    checks++;
    if (frame_got !== frame_exp) begin
      errors++;
      $display("FAIL single_frame: got %b want %b", frame_got, frame_exp);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL single_tx_timing: %0d cycles differ, want 0", bad);
    end
    checks++;
    if (dn !== 1) begin
      errors++;
      $display("FAIL single_done_count: %0d pulses want 1", dn);
    end
    checks++;
    if (dk + 1 !== 43) begin
      errors++;
      $display("FAIL single_done_time: done at cycle %0d want 43", dk + 1);
    end
    checks++;
    if (bbad !== 0 || ov !== 0 || ifc1.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy: bad=%0d overlap=%0d busy_end=%b want 0 0 0", bbad, ov, ifc1.busy);
    end
  endtask

  task automatic test_multi_byte;
    stream3(-10);
    checks++;
    if (rx_n !== 3 || rx_byte[0] !== 8'h00 || rx_byte[1] !== 8'hFF || rx_byte[2] !== 8'h3C) begin
      errors++;
      $display("FAIL multi_rx_bytes: n=%0d got %h %h %h want 3 00 ff 3c",
               rx_n, rx_byte[0], rx_byte[1], rx_byte[2]);
    end
    checks++;
    if (addr_n !== 3 || addr_log[0] !== 4'd0 || addr_log[1] !== 4'd1 || addr_log[2] !== 4'd2 || addr_max > 2) begin
      errors++;
      $display("FAIL multi_addr_seq: n=%0d got %0d %0d %0d max=%0d want 3 0 1 2 max 2",
               addr_n, addr_log[0], addr_log[1], addr_log[2], addr_max);
    end
    checks++;
    if (start_n !== 3 || start_k[0] + 1 !== 3) begin
      errors++;
      $display("FAIL multi_first_start: starts=%0d first at cycle %0d want 3 starts, cycle 3",
               start_n, start_k[0] + 1);
    end
    checks++;
    if (start_k[1] - start_k[0] !== FRAME || start_k[2] - start_k[1] !== FRAME) begin
      errors++;
      $display("FAIL multi_gap: start spacing %0d %0d want %0d (2-cycle gap)",
               start_k[1] - start_k[0], start_k[2] - start_k[1], FRAME);
    end
    checks++;
    if (done_n !== 1 || done_k + 1 !== 127) begin
      errors++;
      $display("FAIL multi_done: count=%0d cycle=%0d want 1 at 127", done_n, done_k + 1);
    end
    checks++;
    if (tx_bad !== 0 || busy_bad !== 0 || overlap !== 0 || frame_err !== 0) begin
      errors++;
      $display("FAIL multi_line: tx_bad=%0d busy_bad=%0d overlap=%0d frame_err=%0d want all 0",
               tx_bad, busy_bad, overlap, frame_err);
    end
  endtask

  task automatic test_start_ignored;
    stream3(60);
    checks++;
    if (rx_n !== 3 || rx_byte[0] !== 8'h00 || rx_byte[1] !== 8'hFF || rx_byte[2] !== 8'h3C) begin
      errors++;
      $display("FAIL ignored_rx_bytes: n=%0d got %h %h %h want 3 00 ff 3c",
               rx_n, rx_byte[0], rx_byte[1], rx_byte[2]);
    end
    checks++;
    if (done_n !== 1 || done_k + 1 !== 127 || tx_bad !== 0 || start_n !== 3) begin
      errors++;
      $display("FAIL ignored_stream: done=%0d at %0d tx_bad=%0d frames=%0d want 1 at 127, 0, 3",
               done_n, done_k + 1, tx_bad, start_n);
    end
  endtask

  task automatic test_reset_mid_frame;
    ifc3.start = 1'b1;
    tick;
    ifc3.start = 1'b0;
    for (int k = 1; k <= 19; k++) tick;
    // k=19 lies in DATA bit 3 of the first byte (0x00): line low
    checks++;
    if (ifc3.tx !== 1'b0 || ifc3.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: tx=%b busy=%b want 0 1", ifc3.tx, ifc3.busy);
    end
    rst = 1'b1;
    tick;
    checks++;
    if (ifc3.tx !== 1'b1 || ifc3.busy !== 1'b0 || ifc3.mem_addr !== 4'd0 || ifc3.done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_apply: tx=%b busy=%b addr=%0d done=%b want 1 0 0 0",
               ifc3.tx, ifc3.busy, ifc3.mem_addr, ifc3.done);
    end
    rst = 1'b0;
    tick;
    tick;
    checks++;
    if (ifc3.tx !== 1'b1 || ifc3.busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_resume: tx=%b busy=%b want 1 0", ifc3.tx, ifc3.busy);
    end
    stream3(-10);
    checks++;
    if (rx_n !== 3 || rx_byte[0] !== 8'h00 || rx_byte[1] !== 8'hFF || rx_byte[2] !== 8'h3C ||
        tx_bad !== 0 || done_k + 1 !== 127) begin
      errors++;
      $display("FAIL midrst_restream: n=%0d got %h %h %h tx_bad=%0d done=%0d want 3 00 ff 3c 0 127",
               rx_n, rx_byte[0], rx_byte[1], rx_byte[2], tx_bad, done_k + 1);
    end
  endtask

  task automatic test_back_to_back;
    int bad, dbad, bbad, ov;
    logic exp_b, exp_d, exp_t;
    bad = 0; dbad = 0; bbad = 0; ov = 0;
    ifc2.start = 1'b1;
    tick;
    for (int k = 0; k <= 175; k++) begin
      if (k > 0) tick;
      // image 1 occupies k=0..84 (done at 84), image 2 restarts at k=85
      if (k < 2 * FRAME + 1) begin
        exp_t = exp_tx(k, 2, 8'h5A, 8'hC3, 8'h00);
      end else if (k < 2 * (2 * FRAME + 1)) begin
        exp_t = exp_tx(k - (2 * FRAME + 1), 2, 8'h5A, 8'hC3, 8'h00);
      end else begin
        exp_t = 1'b1;
      end
      exp_d = (k == 2 * FRAME) || (k == 4 * FRAME + 1);
      exp_b = (k < 2 * FRAME) || (k >= 2 * FRAME + 1 && k < 4 * FRAME + 1);
      if (ifc2.tx !== exp_t) bad++;
      if (ifc2.done !== exp_d) dbad++;
      if (ifc2.busy !== exp_b) bbad++;
      if (ifc2.done === 1'b1 && ifc2.busy === 1'b1) ov++;
      if (k == 2 * FRAME + 1) begin
        checks++;
        if (ifc2.busy !== 1'b1 || ifc2.mem_addr !== 4'd0 || ifc2.done !== 1'b0) begin
          errors++;
          $display("FAIL b2b_refetch: busy=%b addr=%0d done=%b want 1 0 0",
                   ifc2.busy, ifc2.mem_addr, ifc2.done);
        end
      end
      if (k == 100) ifc2.start = 1'b0;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL b2b_tx: %0d cycles differ want 0", bad);
    end
    checks++;
    if (dbad !== 0 || bbad !== 0 || ov !== 0) begin
      errors++;
      $display("FAIL b2b_done_busy: done_bad=%0d busy_bad=%0d overlap=%0d want 0 0 0", dbad, bbad, ov);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem1[i] = 8'h00;
      mem3[i] = 8'h00;
      mem2[i] = 8'h00;
    end
    mem1[0] = 8'hA5;
    mem3[0] = 8'h00; mem3[1] = 8'hFF; mem3[2] = 8'h3C;
    mem2[0] = 8'h5A; mem2[1] = 8'hC3;
    rst = 1'b1;
    ifc1.start = 1'b0; ifc3.start = 1'b0; ifc2.start = 1'b0;

    test_reset;
    test_single_byte;
    test_multi_byte;
    test_start_ignored;
    test_reset_mid_frame;
    test_back_to_back;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
